// File: rtl/rd_port_arbiter_9_if.sv
// Request/response bundle between nine read requesters and the shared
// register-file read-port arbiter.
interface rd_port_arbiter_9_if #(
  parameter int WIDTH = 6
) ();
  logic [8:0]         rd_req;
  logic [9*WIDTH-1:0] rd_addr_in;
  logic               rd_stall;
  logic [8:0]         gnt;
  logic [8:0]         port_sel;
  logic               rd_en;
  logic [WIDTH-1:0]   rd_addr;
  logic [8:0]         data_valid;
  logic [2:0]         inflight_cnt;

  modport master (
    output rd_req, rd_addr_in, rd_stall,
    input  gnt, port_sel, rd_en, rd_addr, data_valid, inflight_cnt
  );

  modport slave (
    input  rd_req, rd_addr_in, rd_stall,
    output gnt, port_sel, rd_en, rd_addr, data_valid, inflight_cnt
  );
endinterface

// File: rtl/rd_port_arbiter_9.sv
// Round-robin arbiter for a 9-requester register-file read port, with a
// fixed-latency return pipeline that strobes data_valid back to the winner.
module rd_port_arbiter_9 #(
  parameter int WIDTH      = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  rd_port_arbiter_9_if.slave bus
);
  localparam int NPORT = 9;

  logic [3:0]                  ptr_r;
  logic [8:0]                  gnt_r;
  logic                        rd_en_r;
  logic [WIDTH-1:0]            rd_addr_r;
  logic [RD_LATENCY-1:0][8:0]  ret_pipe_r;
  logic [2:0]                  inflight_r;

  logic [8:0]       eligible_s;
  logic             win_found_s;
  logic [3:0]       win_idx_s;
  logic [4:0]       cand_sum_s;
  logic [3:0]       cand_idx_s;
  logic [WIDTH-1:0] win_addr_s;
  logic [8:0]       win_onehot_s;
  logic [3:0]       next_ptr_s;
  logic             issue_s;
  logic             returning_s;

  // Winner search: first eligible port at or above ptr, wrapping 8 -> 0.
  // The last grant is masked so a held request cannot win twice in a row.
  always_comb begin
    eligible_s  = bus.rd_req & ~gnt_r;
    win_found_s = 1'b0;
    win_idx_s   = 4'd0;
    cand_sum_s  = 5'd0;
    cand_idx_s  = 4'd0;
    for (int k = 0; k < NPORT; k++) begin
      cand_sum_s  = {1'b0, ptr_r} + 5'(k);
      cand_idx_s  = (cand_sum_s >= 5'd9) ? 4'(cand_sum_s - 5'd9) : cand_sum_s[3:0];
      win_idx_s   = (!win_found_s && eligible_s[cand_idx_s]) ? cand_idx_s : win_idx_s;
      win_found_s = win_found_s | eligible_s[cand_idx_s];
    end
  end

  // Address mux and derived grant controls for the chosen winner.
  always_comb begin
    win_addr_s = '0;
    for (int k = 0; k < NPORT; k++) begin
      win_addr_s = (4'(k) == win_idx_s) ? bus.rd_addr_in[k*WIDTH +: WIDTH] : win_addr_s;
    end
    win_onehot_s = 9'd1 << win_idx_s;
    next_ptr_s   = (win_idx_s == 4'd8) ? 4'd0 : (win_idx_s + 4'd1);
    issue_s      = win_found_s & ~bus.rd_stall;
    returning_s  = |ret_pipe_r[RD_LATENCY-1];
  end

  // Grant, read-enable, address and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= 4'd0;
      gnt_r     <= 9'd0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= '0;
    end else if (issue_s) begin
      ptr_r     <= next_ptr_s;
      gnt_r     <= win_onehot_s;
      rd_en_r   <= 1'b1;
      rd_addr_r <= win_addr_s;
    end else begin
      ptr_r     <= ptr_r;
      gnt_r     <= 9'd0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= '0;
    end
  end

  // Return pipeline keeps running through stalls; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_pipe_r <= '0;
    end else begin
      ret_pipe_r[0] <= gnt_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        ret_pipe_r[i] <= ret_pipe_r[i-1];
      end
    end
  end

  // Outstanding-read counter: issue and return in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 3'd0;
    end else begin
      case ({rd_en_r, returning_s})
        2'b10:   inflight_r <= inflight_r + 3'd1;
        2'b01:   inflight_r <= inflight_r - 3'd1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign bus.gnt          = gnt_r;
  assign bus.port_sel     = gnt_r;
  assign bus.rd_en        = rd_en_r;
  assign bus.rd_addr      = rd_addr_r;
  assign bus.data_valid   = ret_pipe_r[RD_LATENCY-1];
  assign bus.inflight_cnt = inflight_r;
endmodule

// File: tb/tb_rd_port_arbiter_9.sv
// Bench for rd_port_arbiter_9: two instances (RD_LATENCY 1 and 3) share one
// stimulus stream and are compared against a history-based reference model.
module tb_rd_port_arbiter_9;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]     req     = 9'd0;
  logic [9*W-1:0] addr_in = '0;
  logic           stall   = 1'b0;

  rd_port_arbiter_9_if #(.WIDTH(W)) bus1 ();
  rd_port_arbiter_9_if #(.WIDTH(W)) bus3 ();

  assign bus1.rd_req     = req;
  assign bus1.rd_addr_in = addr_in;
  assign bus1.rd_stall   = stall;
  assign bus3.rd_req     = req;
  assign bus3.rd_addr_in = addr_in;
  assign bus3.rd_stall   = stall;

  rd_port_arbiter_9 #(.WIDTH(W), .RD_LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  rd_port_arbiter_9 #(.WIDTH(W), .RD_LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad   = 0;

  // Reference model: pointer, current grant and a history of grant vectors
  int             m_ptr;
  logic [8:0]     m_gnt;
  logic           m_en;
  logic [W-1:0]   m_addr;
  logic [8:0]     m_hist[$];

  typedef struct {
    logic       rst_before;
    logic [8:0] req;
    logic       stall;
    logic [8:0] exp_gnt;
    logic [8:0] exp_dv1;
  } vec_t;
  vec_t tbl[$];

  logic [9*W-1:0] addr_fixed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] addr_of(input int i);
    return W'(i * 5 + 6);
  endfunction

  function automatic logic [W-1:0] addr_for(input logic [8:0] oh);
    for (int i = 0; i < 9; i++) if (oh[i]) return addr_of(i);
    return '0;
  endfunction

  function automatic logic [8:0] hist_at(input int k);
    return (k < m_hist.size()) ? m_hist[k] : 9'd0;
  endfunction

  // Reads still outstanding = grant cycles among the last L cycles
  function automatic int cnt_model(input int lat);
    int c = 0;
    for (int k = 1; k <= lat; k++) if (hist_at(k) != 9'd0) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_gnt  = 9'd0;
    m_en   = 1'b0;
    m_addr = '0;
    m_hist.delete();
  endtask

  task automatic check_model();
    chk("u1_gnt",   64'(bus1.gnt),          64'(m_gnt));
    chk("u1_psel",  64'(bus1.port_sel),     64'(m_gnt));
    chk("u1_en",    64'(bus1.rd_en),        64'(m_en));
    chk("u1_addr",  64'(bus1.rd_addr),      64'(m_addr));
    chk("u1_dv",    64'(bus1.data_valid),   64'(hist_at(1)));
    chk("u1_cnt",   64'(bus1.inflight_cnt), 64'(cnt_model(1)));
    chk("u3_gnt",   64'(bus3.gnt),          64'(m_gnt));
    chk("u3_en",    64'(bus3.rd_en),        64'(m_en));
    chk("u3_addr",  64'(bus3.rd_addr),      64'(m_addr));
    chk("u3_dv",    64'(bus3.data_valid),   64'(hist_at(3)));
    chk("u3_cnt",   64'(bus3.inflight_cnt), 64'(cnt_model(3)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},  64'({bus1.gnt, bus3.gnt}),               64'd0);
    chk({tag, "_psel"}, 64'({bus1.port_sel, bus3.port_sel}),     64'd0);
    chk({tag, "_en"},   64'({bus1.rd_en, bus3.rd_en}),           64'd0);
    chk({tag, "_addr"}, 64'({bus1.rd_addr, bus3.rd_addr}),       64'd0);
    chk({tag, "_dv"},   64'({bus1.data_valid, bus3.data_valid}), 64'd0);
    chk({tag, "_cnt"},  64'({bus1.inflight_cnt, bus3.inflight_cnt}), 64'd0);
  endtask

  // Assert reset between edges, check outputs clear at once, release later
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    req   = 9'd0;
    stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Present inputs for one cycle, advance the model, compare after the edge
  task automatic step(input logic [8:0] r, input logic [9*W-1:0] a, input logic s);
    logic [8:0] elig;
    int w;
    req     = r;
    addr_in = a;
    stall   = s;
    elig = r & ~m_gnt;
    w = -1;
    for (int k = 0; k < 9; k++) begin
      int i;
      i = (m_ptr + k) % 9;
      if (w < 0 && elig[i]) w = i;
    end
    if (w >= 0 && !s) begin
      m_gnt  = 9'd1 << w;
      m_en   = 1'b1;
      m_addr = a[w*W +: W];
      m_ptr  = (w + 1) % 9;
    end else begin
      m_gnt  = 9'd0;
      m_en   = 1'b0;
      m_addr = '0;
    end
    m_hist.push_front(m_gnt);
    if (m_hist.size() > 8) void'(m_hist.pop_back());
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [8:0]     pending;
    logic [W-1:0]   paddr[9];
    int             waitg[9];
    logic [9*W-1:0] a;
    logic [8:0]     r;
    logic [8:0]     g;

    for (int i = 0; i < 9; i++) addr_fixed[i*W +: W] = addr_of(i);
    model_reset();

    // Single request, then round robin with all ports requesting
    tbl.push_back('{1'b1, 9'h008, 1'b0, 9'h008, 9'h000});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h008});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h000});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{(k == 0), 9'h1FF, 1'b0, 9'd1 << (k % 9),
                      (k == 0) ? 9'd0 : (9'd1 << ((k - 1) % 9))});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h001});
    // Wrap-around from ptr 8, then confirm ptr landed on 1
    tbl.push_back('{1'b1, 9'h080, 1'b0, 9'h080, 9'h000});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h080});
    tbl.push_back('{1'b0, 9'h101, 1'b0, 9'h100, 9'h000});
    tbl.push_back('{1'b0, 9'h001, 1'b0, 9'h001, 9'h100});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h001});
    tbl.push_back('{1'b0, 9'h003, 1'b0, 9'h002, 9'h000});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h002});
    // Stall for three cycles, then ports 2 and 5 in order
    tbl.push_back('{1'b1, 9'h024, 1'b1, 9'h000, 9'h000});
    tbl.push_back('{1'b0, 9'h024, 1'b1, 9'h000, 9'h000});
    tbl.push_back('{1'b0, 9'h024, 1'b1, 9'h000, 9'h000});
    tbl.push_back('{1'b0, 9'h024, 1'b0, 9'h004, 9'h000});
    tbl.push_back('{1'b0, 9'h020, 1'b0, 9'h020, 9'h004});
    tbl.push_back('{1'b0, 9'h000, 1'b0, 9'h000, 9'h020});

    #2;
    do_reset("rst0");
    foreach (tbl[n]) begin
      if (tbl[n].rst_before) do_reset("rst_tbl");
      step(tbl[n].req, addr_fixed, tbl[n].stall);
      chk("tbl_gnt",  64'(bus1.gnt),        64'(tbl[n].exp_gnt));
      chk("tbl_en",   64'(bus1.rd_en),      64'(|tbl[n].exp_gnt));
      chk("tbl_addr", 64'(bus1.rd_addr),    64'(addr_for(tbl[n].exp_gnt)));
      chk("tbl_dv1",  64'(bus1.data_valid), 64'(tbl[n].exp_dv1));
    end

    // Latency 3: back-to-back grants to ports 1, 4, 7
    do_reset("rst_lat");
    step(9'h002, addr_fixed, 1'b0);
    step(9'h010, addr_fixed, 1'b0);
    step(9'h080, addr_fixed, 1'b0);
    chk("lat_gnt3", 64'(bus3.gnt), 64'h080);
    step(9'h000, addr_fixed, 1'b0);
    chk("lat_dv_c4",  64'(bus3.data_valid),   64'h002);
    chk("lat_cnt_c4", 64'(bus3.inflight_cnt), 64'd3);
    step(9'h000, addr_fixed, 1'b0);
    chk("lat_dv_c5",  64'(bus3.data_valid),   64'h010);
    step(9'h000, addr_fixed, 1'b0);
    chk("lat_dv_c6",  64'(bus3.data_valid),   64'h080);
    step(9'h000, addr_fixed, 1'b0);
    chk("lat_cnt_c7", 64'(bus3.inflight_cnt), 64'd0);

    // Reset one cycle after a grant: the read never returns
    do_reset("rst_mf0");
    step(9'h001, addr_fixed, 1'b0);
    chk("mf_gnt", 64'(bus3.gnt), 64'h001);
    step(9'h000, addr_fixed, 1'b0);
    do_reset("rst_mf");
    for (int k = 0; k < 5; k++) begin
      step(9'h000, addr_fixed, 1'b0);
      chk("mf_no_dv", 64'({bus1.data_valid, bus3.data_valid}), 64'd0);
    end
    step(9'h1FF, addr_fixed, 1'b0);
    chk("mf_first", 64'(bus3.gnt), 64'h001);
    step(9'h000, addr_fixed, 1'b0);

    // Randomised traffic with rule-abiding requesters and a fairness bound
    do_reset("rst_rnd");
    pending = 9'd0;
    for (int i = 0; i < 9; i++) begin
      paddr[i] = '0;
      waitg[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 9; i++) a[i*W +: W] = paddr[i];
      r = pending;
      step(r, a, ($urandom_range(0, 3) == 0));
      g = bus1.gnt;
      for (int i = 0; i < 9; i++) begin
        if (g[i]) begin
          chk("rnd_fair", 64'(waitg[i] <= 8), 64'd1);
          pending[i] = 1'($urandom_range(0, 1));
          paddr[i]   = W'($urandom);
          waitg[i]   = 0;
        end else if (pending[i]) begin
          if (g != 9'd0) waitg[i]++;
        end else if ($urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          paddr[i]   = W'($urandom);
          waitg[i]   = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
